muldiv_sched: RTL

//  Sequencer for the EX-stage multi-cycle HI/LO datapath. Accepts MULT/MULTU/DIV/DIVU from EX and drives the

---
 rtl/muldiv_sched.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_sched.sv
// muldiv_sched -- sequencer for the EX-stage multi-cycle HI/LO datapath.
// Accepts MULT/MULTU/DIV/DIVU from EX, drives the external pipelined
// multiplier and iterative divider, holds EX stalled while the operation is
// in flight, then issues a single HI/LO write from the DONE state.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               kills any in-flight op (annuls the divider if busy)
//   issue_valid/op      EX muldiv request; op 00 MULT 01 MULTU 10 DIV 11 DIVU
//   src_a, src_b        rs / rt operands
//   mul_*               multiplier start pulse, sign select, operands, result
//   div_*               divider level start, sign, operands, annul, ready, result
//   stall_req           hold EX and earlier stages
//   hi_we/lo_we/*wdata  single-cycle HI/LO write
//   busy, err_timeout   state != IDLE, sticky divider watchdog flag
module muldiv_sched #(
  parameter int MUL_LAT = 2,
  parameter int DIV_MAX = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        issue_valid,
  input  logic [1:0]  issue_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        mul_start,
  output logic        mul_signed,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_annul,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        stall_req,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic        busy,
  output logic        err_timeout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam int CNT_W = 8;

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [31:0]      a_r;
  logic [31:0]      b_r;
  logic             sgn_r;
  logic [31:0]      hi_r;
  logic [31:0]      lo_r;
  logic             err_r;

  logic accept_s;
  logic mul_go_s;
  logic div_go_s;
  logic dz_s;
  logic timeout_s;
  logic we_s;

  // Next-action decode and the combinational handshake outputs
  always_comb begin
    accept_s   = 1'b0;
    mul_go_s   = 1'b0;
    div_go_s   = 1'b0;
    dz_s       = 1'b0;
    timeout_s  = 1'b0;
    we_s       = 1'b0;
    stall_req  = 1'b0;
    div_start  = 1'b0;
    div_annul  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (issue_valid && !flush) begin
          accept_s  = 1'b1;
          stall_req = 1'b1;
          if (!issue_op[1]) begin
            mul_go_s = 1'b1;
          end else if (src_b == 32'd0) begin
            dz_s = 1'b1;   // divide by zero bypasses the divider entirely
          end else begin
            div_go_s  = 1'b1;
            div_start = 1'b1;
          end
        end else begin
          stall_req = 1'b0;
        end
      end
      S_MUL: begin
        stall_req = 1'b1;
      end
      S_DIV: begin
        stall_req = 1'b1;
        if (flush) begin
          div_annul = 1'b1;   // flush beats a same-cycle div_ready
        end else if (div_ready) begin
          div_start = 1'b0;
        end else if (cnt_r == CNT_W'(DIV_MAX)) begin
          div_annul = 1'b1;
          timeout_s = 1'b1;
        end else begin
          div_start = 1'b1;
        end
      end
      S_DONE: begin
        if (!flush) begin
          we_s = 1'b1;
        end else begin
          we_s = 1'b0;
        end
      end
      default: begin
        stall_req = 1'b0;
      end
    endcase
  end

  // Operands come straight from EX in the accept cycle, from latches after it
  always_comb begin
    mul_start  = mul_go_s;
    mul_a      = mul_go_s ? src_a : a_r;
    mul_b      = mul_go_s ? src_b : b_r;
    mul_signed = mul_go_s ? ~issue_op[0] : sgn_r;
    div_a      = div_go_s ? src_a : a_r;
    div_b      = div_go_s ? src_b : b_r;
    div_signed = div_go_s ? ~issue_op[0] : sgn_r;
    hi_we      = we_s;
    lo_we      = we_s;
    hi_wdata   = hi_r;
    lo_wdata   = lo_r;
    busy       = (state_r != S_IDLE);
    err_timeout = err_r;
  end

  // Sequencer state, latency/watchdog counter, operand and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      sgn_r   <= 1'b0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            a_r   <= src_a;
            b_r   <= src_b;
            sgn_r <= ~issue_op[0];
            cnt_r <= CNT_W'(1);
            if (mul_go_s) begin
              state_r <= S_MUL;
            end else if (dz_s) begin
              hi_r    <= src_a;
              lo_r    <= 32'hFFFF_FFFF;
              state_r <= S_DONE;
            end else begin
              state_r <= S_DIV;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_MUL: begin
          if (flush) begin
            state_r <= S_IDLE;
            cnt_r   <= '0;
          end else if (cnt_r == CNT_W'(MUL_LAT)) begin
            hi_r    <= mul_result[63:32];
            lo_r    <= mul_result[31:0];
            cnt_r   <= '0;
            state_r <= S_DONE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_DIV: begin
          if (flush) begin
            state_r <= S_IDLE;
            cnt_r   <= '0;
          end else if (div_ready) begin
            hi_r    <= div_result[63:32];   // remainder
            lo_r    <= div_result[31:0];    // quotient
            cnt_r   <= '0;
            state_r <= S_DONE;
          end else if (timeout_s) begin
            err_r   <= 1'b1;
            cnt_r   <= '0;
            state_r <= S_IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_DONE: begin
          // issue_valid here is the same instruction advancing; never re-issue
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
